// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
// Hazard, forwarding and flush controller for the 5-stage RISC-V pipeline.
// Generates the load-use / stall-only stalls and the multi-cycle data-memory
// wait. It also produces the redirect flushes, including a redirect that
// arrives while the pipe is held. It supplies the EX operand forwarding
// selects, registered alongside ID/EX, and keeps saturating stall/flush
// counters.
// MEM_LAT must stay within 1..4 because the wait counter is two bits wide.

module hazard_forward_unit #(
    parameter int REG_AW      = 5,
    parameter int FWD_EN      = 1,
    parameter int MEM_LAT     = 1,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic              mem_memread,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    input  logic              redirect,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              bubble_idex,
    output logic              stall_back,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              flush_exmem,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              id_byp_rs1,
    output logic              id_byp_rs2,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
);

    // EX operand source encodings.
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam logic       FWD_ON    = (FWD_EN != 0);
    localparam logic       LAT_ON    = (MEM_LAT > 1);
    localparam logic [1:0] LAT_LAST  = 2'(MEM_LAT - 1);
    localparam logic       FLUSH_ID  = (FLUSH_DEPTH >= 2);
    localparam logic       FLUSH_EX  = (FLUSH_DEPTH >= 3);

    // A producer only matters when it writes a non-x0 register the ID
    // instruction really reads.
    function automatic logic writes_src(input logic              regwrite,
                                        input logic [REG_AW-1:0] rd,
                                        input logic [REG_AW-1:0] rs,
                                        input logic              use_rs);
        return regwrite && (rd != '0) && (rd == rs) && use_rs;
    endfunction

    // The younger producer (EX) wins over the older one (MEM).
    function automatic logic [1:0] pick_fwd(input logic ex_hit, input logic mem_hit);
        if (!FWD_ON)  return FWD_RF;
        if (ex_hit)   return FWD_EXMEM;
        if (mem_hit)  return FWD_MEMWB;
        return FWD_RF;
    endfunction

    logic       ex_hit_rs1, ex_hit_rs2;
    logic       mem_hit_rs1, mem_hit_rs2;
    logic       wb_hit_rs1, wb_hit_rs2;
    logic       load_use, data_hazard, mem_wait, redirect_apply;
    logic [1:0] lat_cnt;
    logic       redirect_pend;
    logic [1:0] fwd_a_next, fwd_b_next;

    assign ex_hit_rs1  = writes_src(ex_regwrite,  ex_rd,  id_rs1, id_use_rs1);
    assign ex_hit_rs2  = writes_src(ex_regwrite,  ex_rd,  id_rs2, id_use_rs2);
    assign mem_hit_rs1 = writes_src(mem_regwrite, mem_rd, id_rs1, id_use_rs1);
    assign mem_hit_rs2 = writes_src(mem_regwrite, mem_rd, id_rs2, id_use_rs2);
    assign wb_hit_rs1  = writes_src(wb_regwrite,  wb_rd,  id_rs1, id_use_rs1);
    assign wb_hit_rs2  = writes_src(wb_regwrite,  wb_rd,  id_rs2, id_use_rs2);

    // With forwarding only a load in EX is too late; without it any pending
    // EX or MEM writer of a used source must drain first.
    assign load_use    = ex_memread && (ex_hit_rs1 || ex_hit_rs2);
    assign data_hazard = FWD_ON ? load_use
                                : (ex_hit_rs1 || ex_hit_rs2 || mem_hit_rs1 || mem_hit_rs2);

    // Wait starts when a load sits in MEM with an idle counter and lasts
    // until the counter reaches its last value, giving MEM_LAT-1 held cycles.
    assign mem_wait = LAT_ON && ((lat_cnt == 2'd0) ? mem_memread : (lat_cnt != LAT_LAST));

    // A redirect seen during a wait is applied once the pipe moves again.
    assign redirect_apply = (redirect || redirect_pend) && !mem_wait;

    assign fwd_a_next = pick_fwd(ex_hit_rs1, mem_hit_rs1);
    assign fwd_b_next = pick_fwd(ex_hit_rs2, mem_hit_rs2);

    // Pipeline-register controls; everything is forced low while in reset.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        bubble_idex = 1'b0;
        stall_back  = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        id_byp_rs1  = 1'b0;
        id_byp_rs2  = 1'b0;
        if (!rst) begin
            // A redirect wins over a data hazard so the PC loads the target.
            stall_pc    = mem_wait || (data_hazard && !redirect_apply);
            stall_ifid  = stall_pc;
            bubble_idex = data_hazard && !mem_wait && !redirect_apply;
            stall_back  = mem_wait;
            flush_ifid  = redirect_apply;
            flush_idex  = redirect_apply && FLUSH_ID;
            flush_exmem = redirect_apply && FLUSH_EX;
            id_byp_rs1  = wb_hit_rs1;
            id_byp_rs2  = wb_hit_rs2;
        end
    end

    // Memory wait counter and the pending-redirect flag.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples
        // values from before the edge, independent of statement order.
        if (rst) begin
            lat_cnt       <= 2'd0;
            redirect_pend <= 1'b0;
        end else begin
            if (!LAT_ON) begin
                lat_cnt <= 2'd0;
            end else if (lat_cnt == 2'd0) begin
                if (mem_memread) lat_cnt <= 2'd1;
            end else if (lat_cnt == LAT_LAST) begin
                lat_cnt <= 2'd0;
            end else begin
                lat_cnt <= lat_cnt + 2'd1;
            end
            // Further redirects during a wait merge into the pending one.
            redirect_pend <= mem_wait ? (redirect_pend || redirect) : 1'b0;
        end
    end

    // Forwarding selects travel with ID/EX: hold on a wait, clear on a bubble or squash.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_a <= FWD_RF;
            fwd_b <= FWD_RF;
        end else if (mem_wait) begin
            fwd_a <= fwd_a;
            fwd_b <= fwd_b;
        end else if (bubble_idex || flush_idex) begin
            fwd_a <= FWD_RF;
            fwd_b <= FWD_RF;
        end else begin
            fwd_a <= fwd_a_next;
            fwd_b <= fwd_b_next;
        end
    end

    // Saturating stall-cycle and applied-redirect counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (stall_pc && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
            if (redirect_apply && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit
// Directed bench for hazard_forward_unit. Three instances share one set of
// pipeline inputs: u_fwd (defaults, FLUSH_DEPTH=2), u_stall (FWD_EN=0,
// FLUSH_DEPTH=3) and u_lat (MEM_LAT=3, FLUSH_DEPTH=2). Each scenario resets
// all three and checks the instance it targets.

module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_use_rs1, id_use_rs2, ex_regwrite, ex_memread;
    logic       mem_regwrite, mem_memread, wb_regwrite, redirect;

    logic        f_stall_pc, f_stall_ifid, f_bubble_idex, f_stall_back;
    logic        f_flush_ifid, f_flush_idex, f_flush_exmem, f_id_byp_rs1, f_id_byp_rs2;
    logic [1:0]  f_fwd_a, f_fwd_b;
    logic [15:0] f_stall_cnt, f_flush_cnt;

    logic        s_stall_pc, s_stall_ifid, s_bubble_idex, s_stall_back;
    logic        s_flush_ifid, s_flush_idex, s_flush_exmem, s_id_byp_rs1, s_id_byp_rs2;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [15:0] s_stall_cnt, s_flush_cnt;

    logic        l_stall_pc, l_stall_ifid, l_bubble_idex, l_stall_back;
    logic        l_flush_ifid, l_flush_idex, l_flush_exmem, l_id_byp_rs1, l_id_byp_rs2;
    logic [1:0]  l_fwd_a, l_fwd_b;
    logic [15:0] l_stall_cnt, l_flush_cnt;

    logic [44:0] f_all, s_all, l_all;
    assign f_all = {f_stall_pc, f_stall_ifid, f_bubble_idex, f_stall_back, f_flush_ifid,
                    f_flush_idex, f_flush_exmem, f_fwd_a, f_fwd_b, f_id_byp_rs1,
                    f_id_byp_rs2, f_stall_cnt, f_flush_cnt};
    assign s_all = {s_stall_pc, s_stall_ifid, s_bubble_idex, s_stall_back, s_flush_ifid,
                    s_flush_idex, s_flush_exmem, s_fwd_a, s_fwd_b, s_id_byp_rs1,
                    s_id_byp_rs2, s_stall_cnt, s_flush_cnt};
    assign l_all = {l_stall_pc, l_stall_ifid, l_bubble_idex, l_stall_back, l_flush_ifid,
                    l_flush_idex, l_flush_exmem, l_fwd_a, l_fwd_b, l_id_byp_rs1,
                    l_id_byp_rs2, l_stall_cnt, l_flush_cnt};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_AW(5), .FWD_EN(1), .MEM_LAT(1), .FLUSH_DEPTH(2)) u_fwd (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .mem_rd(mem_rd),
        .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .wb_rd(wb_rd),
        .wb_regwrite(wb_regwrite), .redirect(redirect),
        .stall_pc(f_stall_pc), .stall_ifid(f_stall_ifid), .bubble_idex(f_bubble_idex),
        .stall_back(f_stall_back), .flush_ifid(f_flush_ifid), .flush_idex(f_flush_idex),
        .flush_exmem(f_flush_exmem), .fwd_a(f_fwd_a), .fwd_b(f_fwd_b),
        .id_byp_rs1(f_id_byp_rs1), .id_byp_rs2(f_id_byp_rs2),
        .stall_cnt(f_stall_cnt), .flush_cnt(f_flush_cnt));

    hazard_forward_unit #(.REG_AW(5), .FWD_EN(0), .MEM_LAT(1), .FLUSH_DEPTH(3)) u_stall (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .mem_rd(mem_rd),
        .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .wb_rd(wb_rd),
        .wb_regwrite(wb_regwrite), .redirect(redirect),
        .stall_pc(s_stall_pc), .stall_ifid(s_stall_ifid), .bubble_idex(s_bubble_idex),
        .stall_back(s_stall_back), .flush_ifid(s_flush_ifid), .flush_idex(s_flush_idex),
        .flush_exmem(s_flush_exmem), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
        .id_byp_rs1(s_id_byp_rs1), .id_byp_rs2(s_id_byp_rs2),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

    hazard_forward_unit #(.REG_AW(5), .FWD_EN(1), .MEM_LAT(3), .FLUSH_DEPTH(2)) u_lat (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .mem_rd(mem_rd),
        .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .wb_rd(wb_rd),
        .wb_regwrite(wb_regwrite), .redirect(redirect),
        .stall_pc(l_stall_pc), .stall_ifid(l_stall_ifid), .bubble_idex(l_bubble_idex),
        .stall_back(l_stall_back), .flush_ifid(l_flush_ifid), .flush_idex(l_flush_idex),
        .flush_exmem(l_flush_exmem), .fwd_a(l_fwd_a), .fwd_b(l_fwd_b),
        .id_byp_rs1(l_id_byp_rs1), .id_byp_rs2(l_id_byp_rs2),
        .stall_cnt(l_stall_cnt), .flush_cnt(l_flush_cnt));

    // Advance one clock; inputs are then driven 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = '0; ex_regwrite = 1'b0; ex_memread = 1'b0;
        mem_rd = '0; mem_regwrite = 1'b0; mem_memread = 1'b0;
        wb_rd = '0; wb_regwrite = 1'b0; redirect = 1'b0;
    endtask

    task automatic apply_reset();
        set_idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        step();
        step();
        #2;
        checks++; if (f_all !== '0) begin errors++; $display("FAIL reset_fwd: got %h expected 0", f_all); end
        checks++; if (s_all !== '0) begin errors++; $display("FAIL reset_stall: got %h expected 0", s_all); end
        checks++; if (l_all !== '0) begin errors++; $display("FAIL reset_lat: got %h expected 0", l_all); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_load_use();
        apply_reset();
        // lw x5 in EX, ID reads x5 as rs1.
        ex_rd = 5'd5; ex_regwrite = 1'b1; ex_memread = 1'b1;
        id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        #2;
        checks++; if ({f_stall_pc, f_stall_ifid, f_bubble_idex} !== 3'b111) begin errors++;
            $display("FAIL load_use_stall: got %b expected 111", {f_stall_pc, f_stall_ifid, f_bubble_idex}); end
        checks++; if (f_stall_back !== 1'b0) begin errors++;
            $display("FAIL load_use_no_back: got %b expected 0", f_stall_back); end
        step();
        // Bubble in EX, load now in MEM, ID still reads x5.
        ex_rd = '0; ex_regwrite = 1'b0; ex_memread = 1'b0;
        mem_rd = 5'd5; mem_regwrite = 1'b1; mem_memread = 1'b1;
        #2;
        checks++; if ({f_stall_pc, f_stall_ifid, f_bubble_idex} !== 3'b000) begin errors++;
            $display("FAIL load_use_release: got %b expected 000", {f_stall_pc, f_stall_ifid, f_bubble_idex}); end
        checks++; if (f_fwd_a !== 2'b00) begin errors++;
            $display("FAIL load_use_bubble_fwd: got %b expected 00", f_fwd_a); end
        step();
        checks++; if (f_fwd_a !== 2'b10) begin errors++;
            $display("FAIL load_use_fwd_a: got %b expected 10", f_fwd_a); end
        checks++; if (f_stall_cnt !== 16'd1) begin errors++;
            $display("FAIL load_use_stall_cnt: got %0d expected 1", f_stall_cnt); end
    endtask

    task automatic test_forward_priority();
        apply_reset();
        // add x3 in EX and add x3 in MEM; ID reads rs2=x3.
        ex_rd = 5'd3; ex_regwrite = 1'b1;
        mem_rd = 5'd3; mem_regwrite = 1'b1;
        id_rs2 = 5'd3; id_use_rs2 = 1'b1;
        #2;
        checks++; if ({f_stall_pc, f_bubble_idex} !== 2'b00) begin errors++;
            $display("FAIL fwd_no_stall: got %b expected 00", {f_stall_pc, f_bubble_idex}); end
        step();
        checks++; if ({f_fwd_a, f_fwd_b} !== 4'b0001) begin errors++;
            $display("FAIL fwd_younger_wins: got %b expected 0001", {f_fwd_a, f_fwd_b}); end
        // Both producers target x0.
        ex_rd = 5'd0; mem_rd = 5'd0; id_rs2 = 5'd0;
        step();
        checks++; if (f_fwd_b !== 2'b00) begin errors++;
            $display("FAIL fwd_x0: got %b expected 00", f_fwd_b); end
        // Only MEM writes x3; WB also writes x3 for the ID bypass.
        ex_rd = 5'd3; ex_regwrite = 1'b0; mem_rd = 5'd3; id_rs2 = 5'd3;
        wb_rd = 5'd3; wb_regwrite = 1'b1;
        #2;
        checks++; if ({f_id_byp_rs1, f_id_byp_rs2} !== 2'b01) begin errors++;
            $display("FAIL id_bypass_rs2: got %b expected 01", {f_id_byp_rs1, f_id_byp_rs2}); end
        step();
        checks++; if (f_fwd_b !== 2'b10) begin errors++;
            $display("FAIL fwd_mem_only: got %b expected 10", f_fwd_b); end
    endtask

    task automatic test_stall_only();
        apply_reset();
        // add x7 in EX, ID reads x7.
        ex_rd = 5'd7; ex_regwrite = 1'b1; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
        #2;
        checks++; if ({s_stall_pc, s_stall_ifid, s_bubble_idex} !== 3'b111) begin errors++;
            $display("FAIL stall_only_ex: got %b expected 111", {s_stall_pc, s_stall_ifid, s_bubble_idex}); end
        checks++; if (f_stall_pc !== 1'b0) begin errors++;
            $display("FAIL fwd_mode_no_stall: got %b expected 0", f_stall_pc); end
        step();
        checks++; if ({s_fwd_a, f_fwd_a} !== 4'b0001) begin errors++;
            $display("FAIL stall_only_fwd_sel: got %b expected 0001", {s_fwd_a, f_fwd_a}); end
        // x7 now in MEM, bubble in EX.
        ex_rd = '0; ex_regwrite = 1'b0; mem_rd = 5'd7; mem_regwrite = 1'b1;
        #2;
        checks++; if ({s_stall_pc, s_stall_ifid, s_bubble_idex} !== 3'b111) begin errors++;
            $display("FAIL stall_only_mem: got %b expected 111", {s_stall_pc, s_stall_ifid, s_bubble_idex}); end
        step();
        // x7 now in WB: proceed using the ID bypass.
        mem_rd = '0; mem_regwrite = 1'b0; wb_rd = 5'd7; wb_regwrite = 1'b1;
        #2;
        checks++; if ({s_stall_pc, s_bubble_idex, s_id_byp_rs1} !== 3'b001) begin errors++;
            $display("FAIL stall_only_wb: got %b expected 001", {s_stall_pc, s_bubble_idex, s_id_byp_rs1}); end
        checks++; if (s_stall_cnt !== 16'd2) begin errors++;
            $display("FAIL stall_only_cnt: got %0d expected 2", s_stall_cnt); end
        step();
        checks++; if (s_fwd_a !== 2'b00) begin errors++;
            $display("FAIL stall_only_fwd_held: got %b expected 00", s_fwd_a); end
    endtask

    task automatic test_mem_latency();
        logic [1:0] exp_lat [6]   = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
        logic       exp_stall [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        apply_reset();
        // Two loads back to back through MEM.
        mem_memread = 1'b1; mem_regwrite = 1'b1; mem_rd = 5'd9;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) mem_rd = 5'd10;
            #2;
            checks++; if (u_lat.lat_cnt !== exp_lat[i]) begin errors++;
                $display("FAIL mem_lat_cnt[%0d]: got %0d expected %0d", i, u_lat.lat_cnt, exp_lat[i]); end
            checks++; if ({l_stall_back, l_stall_pc, l_stall_ifid, l_bubble_idex} !== {{3{exp_stall[i]}}, 1'b0}) begin
                errors++;
                $display("FAIL mem_lat_stall[%0d]: got %b expected %b", i,
                         {l_stall_back, l_stall_pc, l_stall_ifid, l_bubble_idex}, {{3{exp_stall[i]}}, 1'b0});
            end
            if (i == 0) begin
                checks++; if (f_stall_back !== 1'b0) begin errors++;
                    $display("FAIL mem_lat1_no_back: got %b expected 0", f_stall_back); end
            end
            step();
        end
        set_idle();
        #2;
        checks++; if (l_stall_cnt !== 16'd4) begin errors++;
            $display("FAIL mem_lat_stall_cnt: got %0d expected 4", l_stall_cnt); end
    endtask

    task automatic test_redirect();
        apply_reset();
        // Redirect together with a load-use hazard.
        redirect = 1'b1;
        ex_rd = 5'd5; ex_regwrite = 1'b1; ex_memread = 1'b1; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        #2;
        checks++; if ({f_flush_ifid, f_flush_idex, f_flush_exmem} !== 3'b110) begin errors++;
            $display("FAIL redirect_depth2: got %b expected 110", {f_flush_ifid, f_flush_idex, f_flush_exmem}); end
        checks++; if ({s_flush_ifid, s_flush_idex, s_flush_exmem} !== 3'b111) begin errors++;
            $display("FAIL redirect_depth3: got %b expected 111", {s_flush_ifid, s_flush_idex, s_flush_exmem}); end
        checks++; if ({f_stall_pc, f_stall_ifid, f_bubble_idex} !== 3'b000) begin errors++;
            $display("FAIL redirect_overrides: got %b expected 000", {f_stall_pc, f_stall_ifid, f_bubble_idex}); end
        step();
        set_idle();
        #2;
        checks++; if ({f_flush_cnt, f_stall_cnt} !== {16'd1, 16'd0}) begin errors++;
            $display("FAIL redirect_counts: got %0d/%0d expected 1/0", f_flush_cnt, f_stall_cnt); end
        checks++; if ({f_flush_ifid, f_flush_idex, f_flush_exmem} !== 3'b000) begin errors++;
            $display("FAIL redirect_one_cycle: got %b expected 000", {f_flush_ifid, f_flush_idex, f_flush_exmem}); end
        step();
        checks++; if (f_flush_cnt !== 16'd1) begin errors++;
            $display("FAIL redirect_cnt_hold: got %0d expected 1", f_flush_cnt); end
    endtask

    task automatic test_redirect_during_wait();
        apply_reset();
        mem_memread = 1'b1; mem_regwrite = 1'b1; mem_rd = 5'd9; redirect = 1'b1;
        #2;
        checks++; if ({l_stall_back, l_flush_ifid, l_flush_idex, l_flush_exmem} !== 4'b1000) begin errors++;
            $display("FAIL pend_wait0: got %b expected 1000", {l_stall_back, l_flush_ifid, l_flush_idex, l_flush_exmem}); end
        step();
        // A second redirect during the wait merges into the pending one.
        #2;
        checks++; if ({l_stall_back, l_flush_ifid, l_flush_idex, l_flush_exmem} !== 4'b1000) begin errors++;
            $display("FAIL pend_wait1: got %b expected 1000", {l_stall_back, l_flush_ifid, l_flush_idex, l_flush_exmem}); end
        step();
        redirect = 1'b0;
        #2;
        checks++; if ({l_stall_back, l_stall_pc, l_flush_ifid, l_flush_idex, l_flush_exmem} !== 5'b00110) begin
            errors++;
            $display("FAIL pend_applied: got %b expected 00110",
                     {l_stall_back, l_stall_pc, l_flush_ifid, l_flush_idex, l_flush_exmem});
        end
        step();
        set_idle();
        #2;
        checks++; if ({l_flush_ifid, l_flush_idex} !== 2'b00) begin errors++;
            $display("FAIL pend_cleared: got %b expected 00", {l_flush_ifid, l_flush_idex}); end
        checks++; if (l_flush_cnt !== 16'd1) begin errors++;
            $display("FAIL pend_merged_cnt: got %0d expected 1", l_flush_cnt); end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        mem_memread = 1'b1; mem_regwrite = 1'b1; mem_rd = 5'd9; redirect = 1'b1;
        step();
        redirect = 1'b0;
        #2;
        checks++; if ({u_lat.lat_cnt, u_lat.redirect_pend} !== 3'b011) begin errors++;
            $display("FAIL mid_reset_setup: got %b expected 011", {u_lat.lat_cnt, u_lat.redirect_pend}); end
        rst = 1'b1;
        step();
        #2;
        checks++; if (l_all !== '0) begin errors++;
            $display("FAIL mid_reset_outputs: got %h expected 0", l_all); end
        rst = 1'b0;
        set_idle();
        #2;
        checks++; if ({l_flush_ifid, l_flush_idex, l_stall_back} !== 3'b000) begin errors++;
            $display("FAIL mid_reset_no_flush: got %b expected 000", {l_flush_ifid, l_flush_idex, l_stall_back}); end
        step();
        #2;
        checks++; if (l_all !== '0) begin errors++;
            $display("FAIL mid_reset_after: got %h expected 0", l_all); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: sim time %0t expected finish before 100000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_idle();
        rst = 1'b1;
        test_reset();
        test_load_use();
        test_forward_priority();
        test_stall_only();
        test_mem_latency();
        test_redirect();
        test_redirect_during_wait();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
